// File: rtl/riscv_apu_wb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_apu_wb_pkg
// Shared definitions for the APU writeback buffer: default widths/depth and
// the buffered entry layout.
//
// Optional feature macro: APU_WB_FLAGS_EN
//   When defined, each entry also carries the APU status flags (fflags) so the
//   top level can accumulate them into a sticky register.
// ---------------------------------------------------------------------------
package riscv_apu_wb_pkg;

  localparam int APU_WB_DEPTH   = 2;
  localparam int APU_WB_DATA_W  = 32;
  localparam int APU_WB_ADDR_W  = 6;
  localparam int APU_WB_FLAGS_W = 5;

  // One buffered APU result: destination register, result data and, when the
  // sticky-flag feature is built in, the status flags that came with it.
  typedef struct packed {
    logic [APU_WB_ADDR_W-1:0]  addr;
    logic [APU_WB_DATA_W-1:0]  data;
`ifdef APU_WB_FLAGS_EN
    logic [APU_WB_FLAGS_W-1:0] flags;
`endif
  } apu_wb_entry_t;

endpackage

// File: rtl/riscv_apu_wb_buffer_if.sv
// ---------------------------------------------------------------------------
// riscv_apu_wb_buffer_if
// Bundles the APU response channel and the regfile write port seen by the
// APU writeback buffer. Signal names keep the buffer's own direction suffixes
// so they read the same on both sides.
//
// Signals (direction as seen by the buffer):
//   apu_master_valid_i / apu_master_result_i / apu_master_flags_i  APU result in
//   apu_waddr_i          destination of the returning result
//   apu_master_ready_o   buffer can accept a result this cycle
//   wb_valid_o / wb_waddr_o / wb_wdata_o  regfile write request
//   wb_ready_i           write port granted to the APU this cycle
//
// Modports:
//   slave  - the buffer itself
//   master - the surrounding pipeline (APU interconnect + regfile arbiter)
// ---------------------------------------------------------------------------
interface riscv_apu_wb_buffer_if
  import riscv_apu_wb_pkg::*;
#(
  parameter int DATA_W  = APU_WB_DATA_W,
  parameter int ADDR_W  = APU_WB_ADDR_W,
  parameter int FLAGS_W = APU_WB_FLAGS_W
);

  logic               apu_master_valid_i;
  logic [DATA_W-1:0]  apu_master_result_i;
  logic [FLAGS_W-1:0] apu_master_flags_i;
  logic [ADDR_W-1:0]  apu_waddr_i;
  logic               apu_master_ready_o;
  logic               wb_valid_o;
  logic [ADDR_W-1:0]  wb_waddr_o;
  logic [DATA_W-1:0]  wb_wdata_o;
  logic               wb_ready_i;

  modport slave (
    input  apu_master_valid_i, apu_master_result_i, apu_master_flags_i,
           apu_waddr_i, wb_ready_i,
    output apu_master_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );

  modport master (
    output apu_master_valid_i, apu_master_result_i, apu_master_flags_i,
           apu_waddr_i, wb_ready_i,
    input  apu_master_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );

endinterface

// File: rtl/riscv_apu_wb_fifo.sv
// ---------------------------------------------------------------------------
// riscv_apu_wb_fifo
// In-order storage for APU results waiting on the shared regfile write port.
// Holds read/write pointers, occupancy count and per-slot valid bits, and
// exports every slot's destination address for the dependency compare.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         store pushEntry_i at the tail (caller guarantees not full)
//   pushEntry_i    entry to store
//   pop_i          retire the head (caller guarantees not empty)
//   headEntry_o    oldest stored entry
//   count_o        occupancy, 0..DEPTH
//   entryValid_o   per-slot "holds a not-yet-written result"
//   entryAddr_o    per-slot destination address
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module riscv_apu_wb_fifo
  import riscv_apu_wb_pkg::*;
#(
  parameter int  DEPTH   = APU_WB_DEPTH,
  parameter int  ADDR_W  = APU_WB_ADDR_W,
  parameter type entry_t = apu_wb_entry_t
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  entry_t                        pushEntry_i,
  input  logic                          pop_i,
  output entry_t                        headEntry_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic [DEPTH-1:0]              entryValid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entryAddr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             entries_q [DEPTH];
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   entryValid_q, entryValid_d;

  // Next-state for pointers, count and slot valid bits. A push and a pop in
  // the same cycle never touch the same slot: that would need the FIFO to be
  // both empty (for the pop to be illegal) and full (for the push to be).
  always_comb begin
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    count_d      = count_q;
    entryValid_d = entryValid_q;
    if (pop_i) begin
      entryValid_d[rdPtr_q] = 1'b0;
      rdPtr_d               = rdPtr_q + PTR_W'(1);
    end
    if (push_i) begin
      entryValid_d[wrPtr_q] = 1'b1;
      wrPtr_d               = wrPtr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers. Reset empties the buffer, dropping anything stored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      entryValid_q <= '0;
    end else begin
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      entryValid_q <= entryValid_d;
    end
  end

  // Entry storage, cleared on reset so no stale address can ever leak out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (push_i) begin
      entries_q[wrPtr_q] <= pushEntry_i;
    end
  end

  // Per-slot destination addresses for the ID-stage hazard check.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entryAddr_o[i] = entries_q[i].addr;
    end
  end

  assign headEntry_o  = entries_q[rdPtr_q];
  assign count_o      = count_q;
  assign entryValid_o = entryValid_q;

endmodule

// File: rtl/riscv_apu_wb_buffer.sv
// ---------------------------------------------------------------------------
// riscv_apu_wb_buffer
// Sits downstream of the APU dispatcher. Takes APU results off the response
// channel, pairs each with its destination address and feeds the shared
// regfile write port. Results wait in order in a small FIFO while the port is
// busy with LSU/ALU writeback; with an empty FIFO a result goes straight
// through in the same cycle. Buffered destinations are flagged to ID as read
// dependencies.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   bus (slave)         APU response channel + regfile write port
//   read_regs_i         three ID-stage source operand addresses
//   read_regs_valid_i   per-operand valid
//   read_dep_o          an operand matches a buffered, not-yet-written result
//   fflags_o            sticky status flags (0 unless APU_WB_FLAGS_EN)
//   fflags_clr_i        clear sticky flags (ignored unless APU_WB_FLAGS_EN)
//
// Optional feature macro: APU_WB_FLAGS_EN (sticky fflags accumulation).
// ---------------------------------------------------------------------------
module riscv_apu_wb_buffer
  import riscv_apu_wb_pkg::*;
#(
  parameter int DEPTH   = APU_WB_DEPTH,
  parameter int DATA_W  = APU_WB_DATA_W,
  parameter int ADDR_W  = APU_WB_ADDR_W,
  parameter int FLAGS_W = APU_WB_FLAGS_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  riscv_apu_wb_buffer_if.slave     bus,
  input  logic [2:0][ADDR_W-1:0]   read_regs_i,
  input  logic [2:0]               read_regs_valid_i,
  output logic                     read_dep_o,
  output logic [FLAGS_W-1:0]       fflags_o,
  input  logic                     fflags_clr_i
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
`ifdef APU_WB_FLAGS_EN
    logic [FLAGS_W-1:0] flags;
`endif
  } entry_t;

  entry_t                       pushEntry;
  entry_t                       headEntry;
  logic [CNT_W-1:0]             fifoCount;
  logic [DEPTH-1:0]             entryValid;
  logic [DEPTH-1:0][ADDR_W-1:0] entryAddr;
  logic                         countZero;
  logic                         accept;
  logic                         push;
  logic                         pop;
  logic                         wbValid;
  logic                         wbWrite;
  logic                         readDep;

  // Handshake. Ready depends only on occupancy so the APU interconnect never
  // sees a combinational path from the regfile arbiter. A new result may only
  // bypass when nothing is buffered, otherwise it would overtake older ones.
  // The write request is masked during reset so nothing lands in the regfile
  // on the cycle the buffer is being flushed.
  assign countZero = (fifoCount == '0);
  assign bus.apu_master_ready_o = (fifoCount != CNT_W'(DEPTH));
  assign accept    = bus.apu_master_valid_i & bus.apu_master_ready_o;
  assign wbValid   = !rst_i && (!countZero || bus.apu_master_valid_i);
  assign wbWrite   = wbValid & bus.wb_ready_i;
  assign push      = accept & !(countZero & bus.wb_ready_i);
  assign pop       = !countZero & bus.wb_ready_i;

  // Pack the incoming result into a FIFO entry.
  always_comb begin
    pushEntry       = '0;
    pushEntry.addr  = bus.apu_waddr_i;
    pushEntry.data  = bus.apu_master_result_i;
`ifdef APU_WB_FLAGS_EN
    pushEntry.flags = bus.apu_master_flags_i;
`endif
  end

  riscv_apu_wb_fifo #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .entry_t (entry_t)
  ) uFifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .pushEntry_i  (pushEntry),
    .pop_i        (pop),
    .headEntry_o  (headEntry),
    .count_o      (fifoCount),
    .entryValid_o (entryValid),
    .entryAddr_o  (entryAddr)
  );

  // Write-port mux: the oldest buffered entry wins; with an empty buffer the
  // live APU result is presented directly. Address/data are held at zero
  // whenever no write is requested so the port never shows stale values.
  always_comb begin
    bus.wb_valid_o = wbValid;
    bus.wb_waddr_o = '0;
    bus.wb_wdata_o = '0;
    if (wbValid) begin
      if (!countZero) begin
        bus.wb_waddr_o = headEntry.addr;
        bus.wb_wdata_o = headEntry.data;
      end else begin
        bus.wb_waddr_o = bus.apu_waddr_i;
        bus.wb_wdata_o = bus.apu_master_result_i;
      end
    end
  end

  // Read-after-write hazard towards ID: any valid operand that names a
  // buffered destination must wait. The result still on the APU channel is
  // deliberately not checked here; the dispatcher already tracks it.
  always_comb begin
    readDep = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int i = 0; i < 3; i++) begin
        if (entryValid[e] && read_regs_valid_i[i] && (read_regs_i[i] == entryAddr[e])) begin
          readDep = 1'b1;
        end
      end
    end
  end

  assign read_dep_o = readDep;

`ifdef APU_WB_FLAGS_EN
  logic [FLAGS_W-1:0] fflags_q, fflags_d;
  logic [FLAGS_W-1:0] wrFlags;

  // Flags of whichever result is being written this cycle; the clear is
  // applied first so a same-cycle write is never lost.
  assign wrFlags = countZero ? bus.apu_master_flags_i : headEntry.flags;

  always_comb begin
    fflags_d = fflags_clr_i ? '0 : fflags_q;
    if (wbWrite) begin
      fflags_d = fflags_d | wrFlags;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic [FLAGS_W-1:0] unusedFlags;
  logic               unusedClr;
  logic               unusedWrite;

  // Flags are not tracked in this build; the inputs are intentionally sunk.
  assign unusedFlags = bus.apu_master_flags_i;
  assign unusedClr   = fflags_clr_i;
  assign unusedWrite = wbWrite;
  assign fflags_o    = '0;
`endif

endmodule

// File: tb/tb_riscv_apu_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_riscv_apu_wb_buffer
// Self-checking bench for riscv_apu_wb_buffer. A scoreboard queue holds every
// result the buffer should currently be storing; each cycle the bench derives
// ready / write request / write address+data / read dependency / sticky flags
// from it and compares against the DUT. Honours APU_WB_FLAGS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_riscv_apu_wb_buffer;

  localparam int DEPTH   = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 6;
  localparam int FLAGS_W = 5;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [FLAGS_W-1:0] flags;
  } sbEntry_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [2:0][ADDR_W-1:0] readRegs;
  logic [2:0]             readValid;
  logic                   readDep;
  logic [FLAGS_W-1:0]     fflags;
  logic                   fflagsClr;

  sbEntry_t               sbQueue [$];
  logic [FLAGS_W-1:0]     modelFflags;
  logic                   lastAccepted;
  int                     compareCount  = 0;
  int                     mismatchCount = 0;

  riscv_apu_wb_buffer_if #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .FLAGS_W (FLAGS_W)
  ) apuWbIf ();

  riscv_apu_wb_buffer #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .FLAGS_W (FLAGS_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .bus               (apuWbIf),
    .read_regs_i       (readRegs),
    .read_regs_valid_i (readValid),
    .read_dep_o        (readDep),
    .fflags_o          (fflags),
    .fflags_clr_i      (fflagsClr)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks the DUT at the falling edge against
  // the scoreboard, then advances the scoreboard as the buffer should.
  task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic [FLAGS_W-1:0] flags,
                               input logic wbReady, input logic clr);
    int                 sizeNow;
    logic               expReady, expValid, expDep, accepted;
    logic [ADDR_W-1:0]  expAddr;
    logic [DATA_W-1:0]  expData;
    logic [FLAGS_W-1:0] expFlags;
    sbEntry_t           newEntry;

    apuWbIf.apu_master_valid_i  = valid;
    apuWbIf.apu_waddr_i         = addr;
    apuWbIf.apu_master_result_i = data;
    apuWbIf.apu_master_flags_i  = flags;
    apuWbIf.wb_ready_i          = wbReady;
    fflagsClr                   = clr;
    @(negedge clk_i);

    sizeNow  = sbQueue.size();
    expReady = (sizeNow != DEPTH);
    expValid = (sizeNow != 0) || valid;
    expAddr  = '0;
    expData  = '0;
    expFlags = '0;
    if (expValid) begin
      if (sizeNow != 0) begin
        expAddr  = sbQueue[0].addr;
        expData  = sbQueue[0].data;
        expFlags = sbQueue[0].flags;
      end else begin
        expAddr  = addr;
        expData  = data;
        expFlags = flags;
      end
    end
    expDep = 1'b0;
    foreach (sbQueue[k]) begin
      for (int i = 0; i < 3; i++) begin
        if (readValid[i] && (readRegs[i] == sbQueue[k].addr)) expDep = 1'b1;
      end
    end

    checkOutput("ready",    64'(apuWbIf.apu_master_ready_o), 64'(expReady));
    checkOutput("wb_valid", 64'(apuWbIf.wb_valid_o),         64'(expValid));
    checkOutput("wb_waddr", 64'(apuWbIf.wb_waddr_o),         64'(expAddr));
    checkOutput("wb_wdata", 64'(apuWbIf.wb_wdata_o),         64'(expData));
    checkOutput("read_dep", 64'(readDep),                    64'(expDep));
    checkOutput("fflags",   64'(fflags),                     64'(modelFflags));

    accepted = valid && expReady;
`ifdef APU_WB_FLAGS_EN
    modelFflags = (clr ? '0 : modelFflags) | ((expValid && wbReady) ? expFlags : '0);
`endif
    if (expValid && wbReady && (sizeNow != 0)) void'(sbQueue.pop_front());
    if (accepted && !((sizeNow == 0) && wbReady)) begin
      newEntry.addr  = addr;
      newEntry.data  = data;
      newEntry.flags = flags;
      sbQueue.push_back(newEntry);
    end
    lastAccepted = accepted;
    @(posedge clk_i);
    #1;
  endtask

  // Holds one result on the APU channel until the buffer takes it, the way
  // the APU interconnect would; bounded so a stuck ready cannot hang the run.
  task automatic holdUntilAccepted(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                   input logic wbReady);
    bit done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      applyStimulus(1'b1, addr, data, 5'b00010, wbReady, 1'b0);
      done = lastAccepted;
    end
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  // Synchronous reset for a number of cycles; no write may appear meanwhile.
  task automatic doReset(input int cycles);
    rst_i                      = 1'b1;
    apuWbIf.apu_master_valid_i = 1'b0;
    apuWbIf.wb_ready_i         = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      checkOutput("rst_wb_valid", 64'(apuWbIf.wb_valid_o), 64'd0);
      checkOutput("rst_wb_waddr", 64'(apuWbIf.wb_waddr_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0;
    sbQueue.delete();
    modelFflags = '0;
  endtask

  task automatic idle(input logic wbReady);
    applyStimulus(1'b0, '0, '0, '0, wbReady, 1'b0);
  endtask

  // Directed scenarios first, then a short random soak.
  initial begin
    rst_i                       = 1'b1;
    apuWbIf.apu_master_valid_i  = 1'b0;
    apuWbIf.apu_waddr_i         = '0;
    apuWbIf.apu_master_result_i = '0;
    apuWbIf.apu_master_flags_i  = '0;
    apuWbIf.wb_ready_i          = 1'b0;
    readRegs                    = '0;
    readValid                   = '0;
    fflagsClr                   = 1'b0;
    modelFflags                 = '0;
    lastAccepted                = 1'b0;

    doReset(2);
    idle(1'b1);

    $display("[TB] bypass and sticky flags");
    applyStimulus(1'b1, 6'd5, 32'hA5A5_A5A5, 5'b00001, 1'b1, 1'b0);
    idle(1'b1);
    applyStimulus(1'b1, 6'd6, 32'h1234_5678, 5'b00100, 1'b1, 1'b0);
    idle(1'b0);
`ifdef APU_WB_FLAGS_EN
    checkOutput("fflags_sticky", 64'(fflags), 64'(5'b00101));
`endif
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
    checkOutput("fflags_cleared", 64'(fflags), 64'd0);

    $display("[TB] buffering while port busy");
    applyStimulus(1'b1, 6'd3, 32'hD3D3_0003, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd4, 32'hD4D4_0004, 5'b01000, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] full with simultaneous pop");
    applyStimulus(1'b1, 6'd10, 32'h0000_000A, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'd11, 32'h0000_000B, 5'b00000, 1'b0, 1'b0);
    holdUntilAccepted(6'd7, 32'h0000_0007, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] read dependency");
    applyStimulus(1'b1, 6'd9, 32'h0000_0009, 5'b00000, 1'b0, 1'b0);
    readRegs  = '0;
    readRegs[0] = 6'd9;
    readValid = 3'b001;
    idle(1'b0);
    checkOutput("dep_r9", 64'(readDep), 64'd1);
    readValid = 3'b000;
    idle(1'b0);
    readRegs[0] = 6'd20;
    readValid = 3'b001;
    applyStimulus(1'b1, 6'd20, 32'h0000_0014, 5'b00000, 1'b0, 1'b0);

    $display("[TB] reset with buffered results");
    readRegs[1] = 6'd9;
    readValid   = 3'b011;
    doReset(1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    readValid = 3'b000;

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      readRegs[0] = ADDR_W'($urandom_range(0, 7));
      readRegs[1] = ADDR_W'($urandom_range(0, 7));
      readRegs[2] = ADDR_W'($urandom_range(0, 7));
      readValid   = 3'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom,
                    FLAGS_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0));
    end
    for (int n = 0; n <= DEPTH; n++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
